// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding fetches and buffers one word for decode.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, fetch_pc, tgt;
  logic        fire, refill, consume;

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_hit;
  assign trap_hit = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign tgt      = trap_hit ? TRAP_VEC : redirect_target;

  always_ff @(posedge clk or posedge reset)
    if (reset) misalign_trap <= 1'b0;
    else       misalign_trap <= trap_hit;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{TRAP_VEC, redirect_target[1:0]};
  assign tgt           = {redirect_target[31:2], 2'b00};
  assign misalign_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  // Next state; a redirect while a response is still owed must swallow it in KILL
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  state_nxt = fire ? WAIT : REQ;
      WAIT: if (imem_rvalid)         state_nxt = REQ;
            else if (redirect_valid) state_nxt = KILL;
      KILL: if (imem_rvalid)         state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req = (state == REQ) && !redirect_valid && (!instr_valid || !stall);
    fire     = imem_req && imem_gnt;
    refill   = (state == WAIT) && imem_rvalid && !redirect_valid;
    consume  = instr_valid && !stall;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc       <= RESET_PC;
      fetch_pc <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= tgt;
    end else if (fire) begin
      fetch_pc <= pc;
      pc       <= pc + 32'd4;
    end

  // Refill beats consume so back-to-back delivery keeps the buffer full
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      if (redirect_valid)  instr_valid <= 1'b0;
      else if (refill)     instr_valid <= 1'b1;
      else if (consume)    instr_valid <= 1'b0;
      if (refill) begin
        instr    <= imem_rdata;
        instr_pc <= fetch_pc;
      end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a transaction-level model of the fetch pipe.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0, reset = 1'b1;
  logic        stall = 0, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_target = 0, imem_rdata = 0;
  logic        imem_req, instr_valid, misalign_trap;
  logic [31:0] imem_addr, instr, instr_pc;

  pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: started = first cycle after reset done; pend = a fetch is owed a response;
  // dead = that response must be dropped; bv/instr/ipc = decode buffer.
  bit          m_started, m_pend, m_dead, m_bv, m_trap;
  logic [31:0] m_pc, m_ppc, m_instr, m_ipc;

  task automatic model_reset();
    m_started = 0; m_pend = 0; m_dead = 0; m_bv = 0; m_trap = 0;
    m_pc = RESET_PC; m_ppc = 0; m_instr = 0; m_ipc = 0;
  endtask

  // Entered at a falling edge, leaves at the next falling edge.
  task automatic step(input bit st, input bit rv, input logic [31:0] tg,
                      input bit gn, input bit rvl, input logic [31:0] rd);
    bit ereq, refill, grant, was_started;
    stall = st; redirect_valid = rv; redirect_target = tg;
    imem_gnt = gn; imem_rvalid = rvl; imem_rdata = rd;
    #1;
    ereq = m_started && !m_pend && !rv && (!m_bv || !st);
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_bv});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
    @(posedge clk);
    was_started = m_started;
    m_started = 1;
    refill = was_started && m_pend && !m_dead && rvl && !rv;
    grant  = ereq && gn;
    if (was_started && m_pend && rvl) m_pend = 0;
    m_trap = 0;
    if (rv) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tg % 4 != 0) begin m_pc = TRAP_VEC; m_trap = 1; end
      else m_pc = tg;
`else
      m_pc = tg - (tg % 4);
`endif
      m_bv = 0;
      if (m_pend) m_dead = 1;
    end else if (grant) begin
      m_pend = 1; m_dead = 0; m_ppc = m_pc; m_pc = m_pc + 32'd4;
    end
    if (refill) begin
      m_bv = 1; m_instr = rd; m_ipc = m_ppc;
    end else if (m_bv && !st) m_bv = 0;
    @(negedge clk);
  endtask

  // Always-granting memory that answers one cycle after grant.
  task automatic fc(input bit st, input bit rv, input logic [31:0] tg);
    step(st, rv, tg, 1'b1, m_pend, $urandom);
  endtask

  task automatic do_reset();
    reset = 1;
    stall = 0; redirect_valid = 0; redirect_target = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit          st, rv, gn, rvl;
    logic [31:0] tg;
    int          guard;
    model_reset();
    do_reset();

    // Sequential fetch 0x0, 0x4, 0x8
    repeat (7) fc(0, 0, 0);
    chk("seq_instr_pc", instr_pc, 32'h8);

    // Buffer full and stalled: no requests, buffer stable
    repeat (5) fc(1, 0, 0);
    chk("stall_addr", imem_addr, 32'hC);
    fc(0, 0, 0);

    // Redirect in WAIT, late response dropped
    step(0, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("kill_valid", {31'b0, instr_valid}, 32'h0);
    chk("kill_addr", imem_addr, 32'h200);

    // Redirect coincident with grant, then with rvalid
    step(0, 1, 32'h300, 1, 0, 0);
    chk("redir_gnt_addr", imem_addr, 32'h300);
    fc(0, 0, 0);
    step(0, 1, 32'h400, 0, 1, 32'h1234_5678);
    chk("redir_rv_valid", {31'b0, instr_valid}, 32'h0);
    chk("redir_rv_addr", imem_addr, 32'h400);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    fc(0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    fc(0, 0, 0);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);

    // Misaligned redirect
    step(0, 1, 32'h102, 0, 0, 0);
    chk("misalign_addr", imem_addr, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_trap_hi", {31'b0, misalign_trap}, 32'h1);
`else
    chk("misalign_trap_lo", {31'b0, misalign_trap}, 32'h0);
`endif
    step(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 9) == 0);
      gn  = ($urandom_range(0, 9) < 7);
      rvl = m_pend && ($urandom_range(0, 2) == 0);
      tg  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : $urandom;
      step(st, rv, tg, gn, rvl, $urandom);
    end

    // Reset with a fetch in flight; its late response must be ignored
    guard = 0;
    while (!m_pend && guard < 20) begin fc(0, 0, 0); guard++; end
    chk("pending_before_reset", {31'b0, m_pend}, 32'h1);
    do_reset();
    step(0, 0, 0, 1, 1, 32'hCAFE_F00D);
    chk("late_rv_valid", {31'b0, instr_valid}, 32'h0);
    repeat (20) fc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch sequencer for the single-issue RISC-V core. Owns the program counter register, drives the PC+4 increment, issues one-outstanding fetch requests to instruction memory, and hands fetched words to decode through a one-entry buffer. Execute-stage branch/jump redirects override sequential fetch and kill any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-redirect trap (only used with PC_MISALIGN_TRAP_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept instruction this cycle
- redirect_valid  in  1  taken branch/jump from execute
- redirect_target  in  32  new PC for redirect
- imem_req  out  1  fetch request (combinational)
- imem_addr  out  32  fetch address, equals pc
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  fetch data returned this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  buffer holds valid instruction
- instr  out  32  buffered instruction
- instr_pc  out  32  address of buffered instruction
- misalign_trap  out  1  one-cycle pulse on misaligned redirect (tied 0 without macro)

## Operation
- States: IDLE, REQ, WAIT, KILL. Exactly one fetch outstanding at any time.
- IDLE: entered on reset; goes to REQ next cycle unconditionally.
- REQ: imem_req = !redirect_valid && (!instr_valid || !stall). On imem_gnt with imem_req high: latch fetch_pc = pc, pc <= pc + 32'd4, go WAIT.
- WAIT: on imem_rvalid: instr <= imem_rdata, instr_pc <= fetch_pc, instr_valid <= 1, go REQ.
- KILL: on imem_rvalid: discard data, go REQ.
- Buffer consume: instr_valid && !stall clears instr_valid unless refilled same cycle (refill wins).
- Redirect (highest priority, any state): pc <= redirect_target; instr_valid <= 0.
  - REQ: imem_req forced low, stay REQ.
  - WAIT without rvalid: go KILL. WAIT with rvalid same cycle: data discarded, go REQ.
  - KILL: stay KILL (or REQ if rvalid same cycle); pc takes latest target.
  - IDLE: pc updated, go REQ.
- PC arithmetic: unsigned 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Sequential PC and targets are word-aligned; pc[1:0] always 2'b00.

## Timing
- Reset values: pc = RESET_PC, state = IDLE, instr_valid = 0, instr = 0, instr_pc = 0, misalign_trap = 0, imem_req = 0.
- First imem_req: second rising edge after reset deassertion (IDLE then REQ).
- Fetch latency: grant at edge N, rvalid at N+k (k ≥ 1), instr_valid high after edge N+k.
- Redirect at edge N: imem_addr = target in REQ from cycle N+1; instr_valid low after edge N.
- Reset mid-fetch: all state cleared immediately; late imem_rvalid in IDLE ignored.

## Configuration
- PC_MISALIGN_TRAP_EN defined: redirect with redirect_target[1:0] != 0 loads pc = TRAP_VEC and pulses misalign_trap for one cycle; kill behaviour identical to normal redirect.
- Not defined: redirect_target[1:0] forced to 2'b00; misalign_trap constant 0; TRAP_VEC unused.

## Test plan
- Reset, imem_gnt=1, rvalid one cycle after grant, stall=0 -> addresses 0x0, 0x4, 0x8 fetched in order; instr_pc matches each.
- Buffer full with stall=1 for 5 cycles -> imem_req stays 0, instr/instr_pc stable; release stall -> next fetch at following PC.
- Redirect to 0x200 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> data dropped, instr_valid stays 0, next imem_addr = 0x200.
- Redirect and imem_gnt same cycle in REQ -> no request issued, next imem_addr = target; redirect coincident with rvalid -> data dropped, go REQ.
- pc = 32'hFFFF_FFFC granted -> next imem_addr = 0x0.
- With PC_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_trap=1 one cycle, next imem_addr = 0x100; without macro -> next imem_addr = 0x100, misalign_trap=0.
